// File: rtl/neuro_pkg.sv
// Shared types and default sizing for the neuron amplitude sweep scheduler.
package neuro_pkg;

  localparam int unsigned NEURON_NO = 2 ** 8;
  localparam int unsigned MU_LEN    = 32;
  localparam int unsigned TS_WID    = 16;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned ADDR_W    = $clog2(NEURON_NO);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH,
    DONE
  } sched_state_t;

endpackage

// File: rtl/ampl_sweep_scheduler_if.sv
// Event/tick inputs and amplitude-RAM drive outputs of the sweep scheduler.
interface ampl_sweep_scheduler_if #(
  parameter int unsigned NEURON_NO = 256,
  parameter int unsigned MU_LEN    = 32,
  parameter int unsigned TS_WID    = 16
);

  localparam int unsigned ADDR_W = $clog2(NEURON_NO);

  logic              ts_tick;
  logic [MU_LEN-1:0] mu_cfg;
  logic              ev_valid;
  logic [ADDR_W-1:0] ev_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              sp_in;
  logic [MU_LEN-1:0] mu_out;
  logic              busy;
  logic              step_done;
  logic [TS_WID-1:0] ts_count;
  logic              ts_overrun;

  modport master (
    output ts_tick, mu_cfg, ev_valid, ev_addr,
    input  wr_en, wr_addr, sp_in, mu_out, busy, step_done, ts_count, ts_overrun
  );

  modport slave (
    input  ts_tick, mu_cfg, ev_valid, ev_addr,
    output wr_en, wr_addr, sp_in, mu_out, busy, step_done, ts_count, ts_overrun
  );

endinterface

// File: rtl/spike_pending_map.sv
// One pending-spike bit per neuron: set by events, test-and-cleared by the sweep.
module spike_pending_map #(
  parameter int unsigned NEURON_NO = 256,
  parameter int unsigned ADDR_W    = $clog2(NEURON_NO)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_bit_c_o
);

  logic [NEURON_NO-1:0] bits_q;
  logic [NEURON_NO-1:0] bits_d;

  // Clear first, then set, so an event landing on the bit being read survives.
  always_comb begin
    bits_d = bits_q;
    if (rd_en_i) begin
      bits_d[rd_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      bits_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign rd_bit_c_o = bits_q[rd_addr_i];

endmodule

// File: rtl/ampl_sweep_scheduler.sv
// Per-timestep sequencer: sweeps every neuron address once per tick and feeds
// pending spikes plus the latched mu value to the amplitude RAM.
module ampl_sweep_scheduler
  import neuro_pkg::*;
#(
  parameter int unsigned NEURON_NO = neuro_pkg::NEURON_NO,
  parameter int unsigned MU_LEN    = neuro_pkg::MU_LEN,
  parameter int unsigned TS_WID    = neuro_pkg::TS_WID
) (
  input  logic                   clk,
  input  logic                   reset,
  ampl_sweep_scheduler_if.slave  bus
);

  localparam int unsigned ADDR_W  = $clog2(NEURON_NO);
  localparam int unsigned FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NEURON_NO - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

  sched_state_t       state_q,     state_d;
  logic               wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
  logic               sp_q,        sp_d;
  logic [MU_LEN-1:0]  mu_q,        mu_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [TS_WID-1:0]  ts_count_q,  ts_count_d;
  logic               overrun_q,   overrun_d;
  logic [FLUSH_W-1:0] flush_q,     flush_d;

  logic rd_en;
  logic rd_bit_c;

  assign rd_en = (state_q == SWEEP);

  spike_pending_map #(
    .NEURON_NO (NEURON_NO),
    .ADDR_W    (ADDR_W)
  ) u_pending (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (bus.ev_valid),
    .set_addr_i (bus.ev_addr),
    .rd_en_i    (rd_en),
    .rd_addr_i  (wr_addr_q),
    .rd_bit_c_o (rd_bit_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    sp_d       = rd_en & rd_bit_c;
    mu_d       = mu_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ts_count_d = ts_count_q;
    overrun_d  = overrun_q | (bus.ts_tick & (state_q != IDLE));
    flush_d    = flush_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ts_tick) begin
          state_d   = SWEEP;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          mu_d      = bus.mu_cfg;
          busy_d    = 1'b1;
        end
      end
      SWEEP: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d   = FLUSH;
          wr_addr_d = '0;
          flush_d   = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        ts_count_d = ts_count_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      sp_q       <= 1'b0;
      mu_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ts_count_q <= '0;
      overrun_q  <= 1'b0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      sp_q       <= sp_d;
      mu_q       <= mu_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ts_count_q <= ts_count_d;
      overrun_q  <= overrun_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.sp_in      = sp_q;
  assign bus.mu_out     = mu_q;
  assign bus.busy       = busy_q;
  assign bus.step_done  = done_q;
  assign bus.ts_count   = ts_count_q;
  assign bus.ts_overrun = overrun_q;

endmodule

// File: tb/tb_ampl_sweep_scheduler.sv
// Directed bench for ampl_sweep_scheduler with an 8-neuron sweep.
module tb_ampl_sweep_scheduler;

  localparam int unsigned N  = 8;
  localparam int unsigned MW = 32;
  localparam int unsigned TW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ampl_sweep_scheduler_if #(.NEURON_NO(N), .MU_LEN(MW), .TS_WID(TW)) bus ();

  ampl_sweep_scheduler #(.NEURON_NO(N), .MU_LEN(MW), .TS_WID(TW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic event_idle(input logic [2:0] addr);
    bus.ev_valid = 1'b1;
    bus.ev_addr  = addr;
    step();
    bus.ev_valid = 1'b0;
  endtask

  // Tick now, then follow the whole sweep cycle by cycle; index -1 disables an injection.
  task automatic do_sweep(input logic [7:0] exp_sp, input logic [31:0] exp_mu,
                          input int ev1_at, input logic [2:0] ev1_addr,
                          input int ev2_at, input logic [2:0] ev2_addr,
                          input int tick_at, input bit tick_in_done,
                          input logic [15:0] exp_ts, input logic exp_ovr);
    logic e;
    bus.ts_tick = 1'b1;
    step();
    bus.ts_tick = 1'b0;
    bus.mu_cfg  = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      e = (i == 0) ? 1'b0 : exp_sp[i-1];
      chk("sweep_wr_en", 32'(bus.wr_en), 32'd1);
      chk("sweep_wr_addr", 32'(bus.wr_addr), 32'(i));
      chk("sweep_busy", 32'(bus.busy), 32'd1);
      chk("sweep_step_done", 32'(bus.step_done), 32'd0);
      chk("sweep_sp_in", 32'(bus.sp_in), 32'(e));
      chk("sweep_mu_out", bus.mu_out, exp_mu);
      bus.ev_valid = (i == ev1_at) || (i == ev2_at);
      bus.ev_addr  = (i == ev1_at) ? ev1_addr : ev2_addr;
      bus.ts_tick  = (i == tick_at);
      step();
    end
    bus.ev_valid = 1'b0;
    bus.ts_tick  = 1'b0;
    chk("flush1_wr_en", 32'(bus.wr_en), 32'd0);
    chk("flush1_sp_in", 32'(bus.sp_in), 32'(exp_sp[7]));
    chk("flush1_busy", 32'(bus.busy), 32'd1);
    chk("flush1_step_done", 32'(bus.step_done), 32'd0);
    step();
    chk("flush2_wr_en", 32'(bus.wr_en), 32'd0);
    chk("flush2_sp_in", 32'(bus.sp_in), 32'd0);
    chk("flush2_step_done", 32'(bus.step_done), 32'd0);
    step();
    chk("done_step_done", 32'(bus.step_done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_wr_en", 32'(bus.wr_en), 32'd0);
    bus.ts_tick = tick_in_done;
    step();
    bus.ts_tick = 1'b0;
    chk("post_step_done", 32'(bus.step_done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_wr_en", 32'(bus.wr_en), 32'd0);
    chk("post_ts_count", 32'(bus.ts_count), 32'(exp_ts));
    chk("post_overrun", 32'(bus.ts_overrun), 32'(exp_ovr));
    chk("post_mu_out", bus.mu_out, exp_mu);
    step();
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.ts_tick  = 1'b0;
    bus.mu_cfg   = '0;
    bus.ev_valid = 1'b0;
    bus.ev_addr  = '0;
    step();
    step();
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ts_count", 32'(bus.ts_count), 32'd0);
    chk("rst_overrun", 32'(bus.ts_overrun), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // 1: no events
    do_sweep(8'h00, 32'h0, -1, 3'd0, -1, 3'd0, -1, 1'b0, 16'd1, 1'b0);

    // 2: events to 3 and 5 before the tick
    bus.mu_cfg = 32'h1234;
    event_idle(3'd3);
    event_idle(3'd5);
    bus.mu_cfg = 32'h1234;
    do_sweep(8'b0010_1000, 32'h1234, -1, 3'd0, -1, 3'd0, -1, 1'b0, 16'd2, 1'b0);

    // 3: addr 7 while at 4 (delivered now), addr 2 while at 6 (next sweep); 3/5 cleared
    bus.mu_cfg = 32'h55;
    do_sweep(8'b1000_0000, 32'h55, 4, 3'd7, 6, 3'd2, -1, 1'b0, 16'd3, 1'b0);

    // 4: event to 4 in the cycle 4 is swept; addr 2 from before delivered
    bus.mu_cfg = 32'hA5A5_0001;
    do_sweep(8'b0000_0100, 32'hA5A5_0001, 4, 3'd4, -1, 3'd0, -1, 1'b0, 16'd4, 1'b0);
    bus.mu_cfg = 32'h7;
    do_sweep(8'b0001_0000, 32'h7, -1, 3'd0, -1, 3'd0, -1, 1'b0, 16'd5, 1'b0);

    // 5: ticks during sweep and in DONE are dropped and flagged
    bus.mu_cfg = 32'h9;
    do_sweep(8'h00, 32'h9, -1, 3'd0, -1, 3'd0, 2, 1'b1, 16'd6, 1'b1);
    bus.mu_cfg = 32'hB;
    event_idle(3'd0);
    event_idle(3'd0);
    bus.mu_cfg = 32'hB;
    do_sweep(8'b0000_0001, 32'hB, -1, 3'd0, -1, 3'd0, -1, 1'b0, 16'd7, 1'b1);

    // 6: reset mid-sweep at wr_addr=5 with pending bits
    bus.mu_cfg = 32'h77;
    event_idle(3'd1);
    event_idle(3'd6);
    bus.mu_cfg  = 32'h77;
    bus.ts_tick = 1'b1;
    step();
    bus.ts_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("r6_wr_addr", 32'(bus.wr_addr), 32'(i));
      chk("r6_sp_in", 32'(bus.sp_in), (i == 2) ? 32'd1 : 32'd0);
      if (i < 5) step();
    end
    rst = 1'b1;
    #1;
    chk("r6_wr_en", 32'(bus.wr_en), 32'd0);
    chk("r6_wr_addr0", 32'(bus.wr_addr), 32'd0);
    chk("r6_sp_in0", 32'(bus.sp_in), 32'd0);
    chk("r6_mu_out", bus.mu_out, 32'd0);
    chk("r6_busy", 32'(bus.busy), 32'd0);
    chk("r6_step_done", 32'(bus.step_done), 32'd0);
    chk("r6_ts_count", 32'(bus.ts_count), 32'd0);
    chk("r6_overrun", 32'(bus.ts_overrun), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    bus.mu_cfg = 32'h0;
    do_sweep(8'h00, 32'h0, -1, 3'd0, -1, 3'd0, -1, 1'b0, 16'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
